// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage definitions: default widths, opcode field, NOP word, FSM encodings.
package instr_fetch_pkg;
    localparam int ADDR_W_DEF  = 16;
    localparam int INSTR_W_DEF = 16;
    localparam int OPC_W       = 4;
    localparam int PC_INC      = 2;
    localparam logic [INSTR_W_DEF-1:0] NOP_INSTR_DEF = '0;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } if_state_e;
endpackage

// File: rtl/instr_fetch_ifid_reg.sv
// Pipeline register with valid bit: flush beats load, otherwise hold.
module ifid_reg #(
    parameter int                 ADDR_W    = 16,
    parameter int                 INSTR_W   = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               flush_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [ADDR_W-1:0]  pc_plus_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc_plus_o
);
    // Flush leaves pc_plus alone; only valid/instr mark the bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_o   <= 1'b0;
            instr_o   <= NOP_INSTR;
            pc_plus_o <= '0;
        end else if (flush_i) begin
            valid_o   <= 1'b0;
            instr_o   <= NOP_INSTR;
        end else if (load_i) begin
            valid_o   <= 1'b1;
            instr_o   <= instr_i;
            pc_plus_o <= pc_plus_i;
        end
    end
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch + IF/ID register with one-entry skid and branch redirect.
// Optional FETCH_PERF_COUNT_EN adds saturating fetch_count/stall_count outputs.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                 ADDR_W    = ADDR_W_DEF,
    parameter int                 INSTR_W   = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ready,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [OPC_W-1:0]   if_opcode,
    output logic [ADDR_W-1:0]  if_pc_plus
`ifdef FETCH_PERF_COUNT_EN
    ,
    output logic [15:0]        fetch_count,
    output logic [15:0]        stall_count
`endif
);
    if_state_e          state_q;
    logic [ADDR_W-1:0]  pc_q, pc_inc;
    logic [INSTR_W-1:0] skid_instr_q;
    logic [ADDR_W-1:0]  skid_pcp_q;

    logic               ld, flush;
    logic [INSTR_W-1:0] ld_instr;
    logic [ADDR_W-1:0]  ld_pcp;

    assign imem_req  = (state_q == S_FETCH);
    assign imem_addr = pc_q;
    assign pc_inc    = pc_q + ADDR_W'(PC_INC);

    always_comb begin
        ld       = 1'b0;
        flush    = 1'b0;
        ld_instr = imem_rdata;
        ld_pcp   = pc_inc;
        if (branch_taken) begin
            flush = 1'b1;
        end else if (state_q == S_FETCH) begin
            if (!stall) begin
                ld    = imem_ready;
                flush = !imem_ready;
            end
        end else if (!stall) begin
            ld       = 1'b1;
            ld_instr = skid_instr_q;
            ld_pcp   = skid_pcp_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            skid_instr_q <= NOP_INSTR;
            skid_pcp_q   <= '0;
        end else if (branch_taken) begin
            state_q <= S_FETCH;
            pc_q    <= branch_target & ~ADDR_W'(1);
        end else begin
            case (state_q)
                S_FETCH: if (imem_ready) begin
                    pc_q <= pc_inc;
                    if (stall) begin
                        skid_instr_q <= imem_rdata;
                        skid_pcp_q   <= pc_inc;
                        state_q      <= S_HOLD;
                    end
                end
                S_HOLD: if (!stall) state_q <= S_FETCH;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    ifid_reg #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP_INSTR)) u_ifid (
        .clk       (clk),
        .rst       (rst),
        .load_i    (ld),
        .flush_i   (flush),
        .instr_i   (ld_instr),
        .pc_plus_i (ld_pcp),
        .valid_o   (if_valid),
        .instr_o   (if_instr),
        .pc_plus_o (if_pc_plus)
    );

    assign if_opcode = if_instr[INSTR_W-1 -: OPC_W];

`ifdef FETCH_PERF_COUNT_EN
    logic [15:0] fetch_cnt_q, stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (ld && fetch_cnt_q != 16'hFFFF) fetch_cnt_q <= fetch_cnt_q + 16'd1;
            if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign stall_count = stall_cnt_q;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// Randomized scoreboard bench for instr_fetch against a word-queue reference model.
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_ready;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [3:0]  if_opcode;
    logic [15:0] if_pc_plus;
`ifdef FETCH_PERF_COUNT_EN
    logic [15:0] fetch_count, stall_count;
`endif

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .if_valid(if_valid), .if_instr(if_instr), .if_opcode(if_opcode),
        .if_pc_plus(if_pc_plus)
`ifdef FETCH_PERF_COUNT_EN
        , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] h;
        h = a * 16'h9E37;
        return h ^ 16'hF00D ^ {a[4:1], 12'h000};
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pcp;
    } exp_t;

    exp_t        q[$];
    int          total = 0, bad = 0;
    int          n_fetch = 0, n_stall = 0;
    logic [15:0] m_pc;
    bit          m_held;
    bit          armed = 0, last_stall = 0, last_branch = 0;
    logic        hold_valid;
    logic [15:0] hold_instr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: check fetch interface against the model, drive inputs, advance the model.
    task automatic cyc(input bit r, input bit s, input bit b, input logic [15:0] t);
        @(negedge clk);
        rst = 1'b0;
        chk("imem_req", {31'b0, imem_req}, {31'b0, !m_held});
        if (!m_held) chk("imem_addr", {16'b0, imem_addr}, {16'b0, m_pc});
        imem_ready = r; stall = s; branch_taken = b; branch_target = t;
        @(posedge clk);
        if (b) begin
            m_pc   = t & 16'hFFFE;
            m_held = 0;
            q.delete();
        end else if (!m_held) begin
            if (r) begin
                q.push_back('{instr: mem_word(m_pc), pcp: m_pc + 16'd2});
                m_pc = m_pc + 16'd2;
                m_held = s;
            end
        end else if (!s) begin
            m_held = 0;
        end
        if (s) n_stall++;
        last_stall = s; last_branch = b; armed = 1;
    endtask

    task automatic rst_pulse();
        #3 rst = 1'b1;
        #1;
        chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_if_instr", {16'b0, if_instr}, 32'd0);
        chk("rst_if_pc_plus", {16'b0, if_pc_plus}, 32'd0);
        chk("rst_imem_req", {31'b0, imem_req}, 32'd1);
        chk("rst_imem_addr", {16'b0, imem_addr}, 32'd0);
        m_pc = 16'h0000; m_held = 0; q.delete(); armed = 0;
        n_fetch = 0; n_stall = 0;
    endtask

    // Monitor: after every edge, decide what IF/ID must show and pop on each new load.
    always @(negedge clk) begin
        exp_t e;
        if (armed && !rst) begin
            if (last_branch) begin
                chk("flush_valid", {31'b0, if_valid}, 32'd0);
                chk("flush_instr", {16'b0, if_instr}, 32'd0);
            end else if (last_stall) begin
                chk("stall_hold_valid", {31'b0, if_valid}, {31'b0, hold_valid});
                chk("stall_hold_instr", {16'b0, if_instr}, {16'b0, hold_instr});
            end else if (if_valid) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious_load actual=%h expected=none at %0t", if_instr, $time);
                end else begin
                    e = q.pop_front();
                    n_fetch++;
                    chk("load_instr", {16'b0, if_instr}, {16'b0, e.instr});
                    chk("load_pc_plus", {16'b0, if_pc_plus}, {16'b0, e.pcp});
                    chk("load_opcode", {28'b0, if_opcode}, {28'b0, e.instr[15:12]});
                end
            end else begin
                chk("bubble_instr", {16'b0, if_instr}, 32'd0);
                chk("bubble_no_pending", q.size(), 32'd0);
            end
        end
        hold_valid = if_valid;
        hold_instr = if_instr;
    end

    initial begin
        logic [15:0] tgt;
        rst = 1'b1; imem_ready = 0; stall = 0; branch_taken = 0; branch_target = 0;
        m_pc = 16'h0000; m_held = 0;
        #2;
        chk("init_if_valid", {31'b0, if_valid}, 32'd0);
        chk("init_if_instr", {16'b0, if_instr}, 32'd0);
        chk("init_if_pc_plus", {16'b0, if_pc_plus}, 32'd0);
        chk("init_imem_req", {31'b0, imem_req}, 32'd1);
        chk("init_imem_addr", {16'b0, imem_addr}, 32'd0);

        // streaming, then memory not ready at 0004
        repeat (2) cyc(1, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        // stall the cycle 0006 returns, hold 4 cycles, release, resume at 0008
        cyc(1, 1, 0, 0);
        repeat (3) cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        // stall with memory not ready: everything holds
        cyc(0, 1, 0, 0);
        // branch while holding a skid word, odd target
        cyc(1, 1, 0, 0);
        cyc(1, 1, 1, 16'h0041);
        cyc(1, 0, 0, 0);
        // PC wrap
        cyc(0, 0, 1, 16'hFFFE);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        // async reset mid-stall
        cyc(1, 1, 0, 0);
        rst_pulse();

        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0: tgt = 16'hFFFE;
                1: tgt = 16'h0041;
                default: tgt = 16'($urandom);
            endcase
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 15) == 0, tgt);
            if ($urandom_range(0, 499) == 0) rst_pulse();
        end
        @(negedge clk);
        #1;
`ifdef FETCH_PERF_COUNT_EN
        chk("fetch_count", {16'b0, fetch_count}, (n_fetch > 65535) ? 32'hFFFF : 32'(n_fetch));
        chk("stall_count", {16'b0, stall_count}, (n_stall > 65535) ? 32'hFFFF : 32'(n_stall));
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
